// File: rtl/ssd_scan_driver_if.sv
// Digit-data and display-drive bundle for ssd_scan_driver.
// master drives the digit data and load strobe; slave drives the segment outputs.
interface ssd_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, dp_in, blank_in, load,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, dp_in, blank_in, load,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-atomic double-buffered digit data.
// Define SSD_LZ_SUPPRESS_EN to compile in leading-zero suppression.
module ssd_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    ssd_scan_driver_if.slave  bus
);
    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick, wrap;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank;
    logic [NUM_DIGITS-1:0] eff_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SSD_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    // Walk down from the top digit; a digit is suppressed while every nibble from it upward is zero.
    always_comb begin
        logic zero_run;
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            zero_run   = zero_run && (act_val_q[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run && !act_dp_q[k];
        end
    end

    assign eff_blank = act_blank_q | lz_mask;
`else
    assign eff_blank = act_blank_q;
`endif

    // Scan timing, buffer management and next output values.
    always_comb begin
        presc_d      = presc_q + PW'(1);
        idx_d        = idx_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_vld_d   = pend_vld_q;
        cur_nib      = 4'h0;
        cur_dp       = 1'b0;
        cur_blank    = 1'b1;
        an_d         = '1;

        tick = (presc_q == PW'(REFRESH_DIV - 1));
        wrap = tick && (idx_q == IW'(NUM_DIGITS - 1));

        if (tick) begin
            presc_d = '0;
            idx_d   = wrap ? '0 : idx_q + IW'(1);
        end

        // Active data only ever changes on the frame boundary.
        if (wrap && bus.load) begin
            act_val_d   = bus.value;
            act_dp_d    = bus.dp_in;
            act_blank_d = bus.blank_in;
            pend_vld_d  = 1'b0;
        end else if (wrap && pend_vld_q) begin
            act_val_d   = pend_val_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
            pend_vld_d  = 1'b0;
        end else if (bus.load) begin
            pend_val_d   = bus.value;
            pend_dp_d    = bus.dp_in;
            pend_blank_d = bus.blank_in;
            pend_vld_d   = 1'b1;
        end

        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = act_val_q[4*k +: 4];
                cur_dp    = act_dp_q[k];
                cur_blank = eff_blank[k];
                if (!eff_blank[k] && (presc_q != '0)) begin
                    an_d[k] = 1'b0;
                end
            end
        end

        seg_d = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
        dp_d  = cur_blank | ~cur_dp;

        // Look ahead one cycle so the registered pulse lands on the wrap cycle itself.
        frame_done_d = (presc_d == PW'(REFRESH_DIV - 1)) && (idx_d == IW'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_vld_q   <= 1'b0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_vld_q   <= pend_vld_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: time-based reference model, directed scenarios, random loads and resets.
module tb_ssd_scan_driver;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [3:0] AN_SEQ [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                           4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } lit_t;

    logic clk;
    logic rst;
    ssd_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    ssd_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    lit_t lit_q [$];
    lit_t lit_e;

    // Reference model: scan position is pure arithmetic on cycles since reset.
    int   m_t;
    bit   m_valid = 1'b0;
    int   m_nib [ND], m_pnib [ND];
    bit   m_dp [ND], m_pdp [ND], m_bl [ND], m_pbl [ND];
    bit   m_pv;
    logic [6:0] e_seg;
    logic e_dp, e_fd;
    logic [ND-1:0] e_an;
    int   mp, mi;
    bit   mblank, mwrap;

    function automatic bit model_blank(int d);
        bit r;
        r = m_bl[d];
`ifdef SSD_LZ_SUPPRESS_EN
        if (d > 0 && !m_dp[d]) begin
            bit allz;
            allz = 1'b1;
            for (int j = d; j < ND; j++) if (m_nib[j] != 0) allz = 1'b0;
            if (allz) r = 1'b1;
        end
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ND; k++) begin
                m_nib[k] = 0; m_dp[k] = 0; m_bl[k] = 0;
            end
            m_pv = 0; m_t = 0; m_valid = 1'b1;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = '1; e_fd = 1'b0;
        end else if (m_valid) begin
            mp     = m_t % RD;
            mi     = (m_t / RD) % ND;
            mblank = model_blank(mi);
            e_seg  = mblank ? 7'h7F : SEG_TAB[m_nib[mi]];
            e_dp   = mblank ? 1'b1 : !m_dp[mi];
            e_an   = '1;
            if (mp != 0 && !mblank) e_an[mi] = 1'b0;
            mwrap = (mp == RD - 1) && (mi == ND - 1);
            if (mwrap && bus.load) begin
                for (int k = 0; k < ND; k++) begin
                    m_nib[k] = int'(bus.value[4*k +: 4]); m_dp[k] = bus.dp_in[k]; m_bl[k] = bus.blank_in[k];
                end
                m_pv = 0;
            end else if (mwrap && m_pv) begin
                for (int k = 0; k < ND; k++) begin
                    m_nib[k] = m_pnib[k]; m_dp[k] = m_pdp[k]; m_bl[k] = m_pbl[k];
                end
                m_pv = 0;
            end else if (bus.load) begin
                for (int k = 0; k < ND; k++) begin
                    m_pnib[k] = int'(bus.value[4*k +: 4]); m_pdp[k] = bus.dp_in[k]; m_pbl[k] = bus.blank_in[k];
                end
                m_pv = 1;
            end
            m_t++;
            e_fd = ((m_t % RD) == RD - 1) && (((m_t / RD) % ND) == ND - 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Single compare process: queued literal checks plus per-cycle model comparison.
    always @(negedge clk) begin
        while (lit_q.size() > 0) begin
            lit_e = lit_q.pop_front();
            chk(lit_e.name, lit_e.got, lit_e.exp);
        end
        if (m_valid) begin
            chk("seg", 32'(bus.seg), 32'(e_seg));
            chk("dp", 32'(bus.dp), 32'(e_dp));
            chk("an", 32'(bus.an), 32'(e_an));
            chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
            chk("an_at_most_one_low", 32'($countones(~bus.an) <= 1), 32'd1);
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        lit_t e;
        e.name = name; e.got = got; e.exp = exp;
        lit_q.push_back(e);
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bl);
        bus.value = v; bus.dp_in = dpv; bus.blank_in = bl; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.frame_done) return;
        end
        lit({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_an(input string name, input logic [3:0] target);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.an == target) return;
        end
        lit({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    int fd_cnt;
    int hit;

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        lit("rst_seg", 32'(bus.seg), 32'h7F);
        lit("rst_an", 32'(bus.an), 32'hF);
        lit("rst_dp", 32'(bus.dp), 32'd1);
        lit("rst_fd", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;

        // Idle scan pattern after reset
        fd_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            lit("idle_an_seq", 32'(bus.an), 32'(AN_SEQ[i]));
            if (bus.an != 4'hF) lit("idle_seg0", 32'(bus.seg), 32'h40);
            fd_cnt += int'(bus.frame_done);
        end
        lit("idle_fd_count", 32'(fd_cnt), 32'd1);

        // Mid-frame load takes effect only after the next wrap
        repeat (3) @(negedge clk);
        load_word(16'h1A3F, 4'h0, 4'h0);
        wait_fd("load1a3f_fd");
        wait_an("load1a3f_d1", 4'hD);
        lit("load1a3f_d1_seg", 32'(bus.seg), 32'h30);
        wait_an("load1a3f_d2", 4'hB);
        lit("load1a3f_d2_seg", 32'(bus.seg), 32'h08);

        // Two loads in one frame: last one wins
        load_word(16'h1111, 4'h0, 4'h0);
        load_word(16'h2222, 4'h0, 4'h0);
        wait_fd("dbl_fd");
        wait_an("dbl_d0", 4'hE);
        lit("dbl_d0_seg", 32'(bus.seg), 32'h24);
        wait_an("dbl_d3", 4'h7);
        lit("dbl_d3_seg", 32'(bus.seg), 32'h24);

        // Load on the wrap cycle goes straight to active
        wait_fd("wrapload_fd");
        load_word(16'h0005, 4'h0, 4'h0);
        wait_an("wrapload_d0", 4'hE);
        lit("wrapload_d0_seg", 32'(bus.seg), 32'h12);

        // Blank and decimal-point handling
        load_word(16'h4321, 4'b0101, 4'b0100);
        wait_fd("blank_fd");
        wait_an("blank_d0", 4'hE);
        lit("dp_d0_lit", 32'(bus.dp), 32'd0);
        wait_an("blank_d1", 4'hD);
        lit("dp_d1_dark", 32'(bus.dp), 32'd1);
        hit = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.an == 4'hB) hit++;
        end
        lit("blank_d2_never_on", 32'(hit), 32'd0);

        // Random loads and occasional mid-frame resets
        for (int i = 0; i < 600; i++) begin
            bus.value    = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & 32'h00F0);
            bus.dp_in    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            bus.blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bus.load     = ($urandom_range(0, 5) == 0);
            rst          = ($urandom_range(0, 119) == 0);
            @(negedge clk);
        end
        rst = 1'b0; bus.load = 1'b0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
